nios2_debug_slave_sysclk_fifo: RTL and testbench
================================================

Name: nios2_debug_slave_sysclk_fifo

Overview:
- Parametrised system-clock side of the Nios II JTAG debug slave; successor to the fixed 38-bit, 2-bit-IR, unbuffered sysclk capture block.
- Synchronises the virtual-JTAG update strobes into clk and captures IR/shift-register contents.
- Buffers up to FIFO_DEPTH commands with a valid/ready handshake toward the OCI logic.
- Decodes each popped command into per-IR-channel take_action / take_no_action pulses.

Parameters:
SR_WIDTH, 38, shift-register / jdo width
IR_WIDTH, 2, instruction register width; channel count NCH = 2**IR_WIDTH
FIFO_DEPTH, 4, command buffer entries; power of two, >= 2
SYNC_STAGES, 2, synchroniser flops per strobe, >= 2
ACTION_BIT, 35, sr bit selecting action (1) vs no-action (0); < SR_WIDTH

Ports:
clk  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
ir_in  in  IR_WIDTH  virtual-JTAG IR, stable while vs_udr/vs_uir high
sr  in  SR_WIDTH  JTAG shift register, stable while vs_udr high
vs_uir  in  1  update-IR level, asynchronous to clk
vs_udr  in  1  update-DR level, asynchronous to clk
cmd_ready  in  1  consumer accepts head command
overflow_clr  in  1  clears sticky overflow
cmd_valid  out  1  FIFO non-empty
jdo  out  SR_WIDTH  data of last popped command, held until next pop
take_action  out  NCH  one-hot 1-cycle pulse, bit = popped IR
take_no_action  out  NCH  one-hot 1-cycle pulse, bit = popped IR
overflow  out  1  sticky: command dropped on full FIFO
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset (reset_n low at clk edge): synchroniser stages 0, edge-detect history 0, arm bits 0, ir_hold 0, FIFO empty, cmd_valid 0, jdo 0, take_* 0, overflow 0, fifo_level 0. Reset mid-operation discards all buffered commands.
- Each strobe passes through SYNC_STAGES flops, then one history flop. An edge is counted when synced=1, history=0 and arm=1.
- arm is set the first cycle synced=0 is seen after reset. A strobe held high across reset therefore produces no command until it goes low and high again.
- uir edge: ir_hold <= ir_in.
- udr edge: push {ir_hold, sr} (sr sampled in the edge-detect cycle E).
- Push in cycle E: cmd_valid and fifo_level update in E+1.
- Pop occurs when cmd_valid && cmd_ready, in cycle P. In P+1:
  - jdo = popped sr;
  - take_action[ir] = sr[ACTION_BIT];
  - take_no_action[ir] = ~sr[ACTION_BIT];
  - all other take_* bits are 0.
- take_* are 0 in every cycle not directly following a pop.
- Minimum udr-rise to take_* latency: SYNC_STAGES+2 cycles with cmd_ready high.
- FIFO: circular, pointers wrap modulo FIFO_DEPTH, order preserved.
  - Push when full and no pop: command dropped, overflow <= 1, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, level unchanged, no overflow.
  - Push and pop in the same cycle when non-empty: both succeed, level unchanged.
  - Pop never occurs when empty.
- overflow_clr clears overflow. If a drop and overflow_clr occur in the same cycle, overflow stays 1 (set wins).
- Simultaneous uir and udr edges in one cycle: the push uses the ir_hold value from before the update; the new IR applies to the next command.
- cmd_ready may be held high permanently; there is no combinational path from cmd_ready to cmd_valid.

Test Plan:
- Single command: ir_hold=2, sr=38'h08_0000_1234 (bit35=1), cmd_ready=1, one udr pulse -> exactly one cycle with take_action=4'b0100, take_no_action=0; jdo=38'h08_0000_1234, held afterwards.
- No-action decode: ir=3, sr bit35=0 -> take_no_action=4'b1000, take_action=0; jdo updated.
- Fill/overflow: cmd_ready=0, five udr pulses with sr=1..5 -> fifo_level=4, overflow=1. Then cmd_ready=1 -> jdo sequence 1,2,3,4; cmd_valid then 0.
- Full simultaneous push/pop: FIFO holds 4, cmd_ready=1 at the push edge -> level stays 4, overflow stays 0, new entry appears 4th.
- Reset with vs_udr held high throughout and after release -> no cmd_valid. Then drop vs_udr low, raise it -> one command.
- overflow_clr asserted in the same cycle as a drop -> overflow=1. overflow_clr alone next cycle -> overflow=0.

Source files
------------

// File: rtl/nios2_debug_slave_sysclk_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nios2_debug_slave_sysclk_fifo
// Brief    : System-clock side of the Nios II JTAG debug slave. Synchronises
//            the virtual-JTAG update strobes, captures IR / shift-register
//            contents into a small command FIFO, and decodes each popped
//            command into per-channel take_action / take_no_action pulses.
// Revision : 1.0 - parametrised, buffered successor of the fixed sysclk block
// ============================================================================
module nios2_debug_slave_sysclk_fifo #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACTION_BIT  = 35
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [IR_WIDTH-1:0]             ir_in,
  input  logic [SR_WIDTH-1:0]             sr,
  input  logic                            vs_uir,
  input  logic                            vs_udr,
  input  logic                            cmd_ready,
  input  logic                            overflow_clr,
  output logic                            cmd_valid,
  output logic [SR_WIDTH-1:0]             jdo,
  output logic [(1 << IR_WIDTH)-1:0]      take_action,
  output logic [(1 << IR_WIDTH)-1:0]      take_no_action,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int NCH = 1 << IR_WIDTH;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int EW  = IR_WIDTH + SR_WIDTH;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Strobe synchronisation and edge detection
  // --------------------------------------------------------------------------
  // prime_pipe marks when the synchroniser chains hold real samples of the
  // strobes rather than their reset zeros. Without it the reset zeros would
  // arm the detector and a strobe held high across reset would look like a
  // fresh rising edge once it propagated through.
  logic [SYNC_STAGES-1:0] prime_pipe;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_hist;
  logic                   udr_hist;
  logic                   uir_arm;
  logic                   udr_arm;
  logic                   prime_done;
  logic                   uir_synced;
  logic                   udr_synced;
  logic                   uir_edge;
  logic                   udr_edge;

  assign prime_done = prime_pipe[SYNC_STAGES-1];
  assign uir_synced = uir_sync[SYNC_STAGES-1];
  assign udr_synced = udr_sync[SYNC_STAGES-1];

  // Synchroniser chains, history flops and arm bits for both update strobes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prime_pipe <= '0;
      uir_sync   <= '0;
      udr_sync   <= '0;
      uir_hist   <= 1'b0;
      udr_hist   <= 1'b0;
      uir_arm    <= 1'b0;
      udr_arm    <= 1'b0;
    end else begin
      prime_pipe <= {prime_pipe[SYNC_STAGES-2:0], 1'b1};
      uir_sync   <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync   <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_hist   <= uir_synced;
      udr_hist   <= udr_synced;
      uir_arm    <= uir_arm | (prime_done & ~uir_synced);
      udr_arm    <= udr_arm | (prime_done & ~udr_synced);
    end
  end

  // Rising edge of each synchronised strobe, qualified by its arm bit
  always_comb begin
    uir_edge = uir_synced & ~uir_hist & uir_arm;
    udr_edge = udr_synced & ~udr_hist & udr_arm;
  end

  // --------------------------------------------------------------------------
  // IR capture
  // --------------------------------------------------------------------------
  logic [IR_WIDTH-1:0] ir_hold;

  // Latch the virtual IR on each update-IR edge; a push in the same cycle
  // still sees the previous value because it reads the flop output
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_hold <= '0;
    end else if (uir_edge) begin
      ir_hold <= ir_in;
    end
  end

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       count;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;
  logic [EW-1:0]       head;
  logic [IR_WIDTH-1:0] head_ir;
  logic [SR_WIDTH-1:0] head_sr;
  logic [NCH-1:0]      head_onehot;

  // cmd_valid derives only from the registered count, so cmd_ready never
  // reaches it combinationally
  assign cmd_valid  = (count != '0);
  assign fifo_level = count;

  // Push/pop qualification; a push into a full FIFO survives only when the
  // head is leaving in the same cycle
  always_comb begin
    full = (count == FULL_LEVEL);
    pop  = cmd_valid & cmd_ready;
    push = udr_edge & (~full | pop);
    drop = udr_edge & full & ~pop;
  end

  // Storage array, written at the tail without reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= {ir_hold, sr};
    end
  end

  // Circular pointers and occupancy counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Command decode
  // --------------------------------------------------------------------------
  assign head    = mem[rd_ptr];
  assign head_ir = head[EW-1:SR_WIDTH];
  assign head_sr = head[SR_WIDTH-1:0];

  // One-hot channel select for the command at the head of the FIFO
  always_comb begin
    head_onehot          = '0;
    head_onehot[head_ir] = 1'b1;
  end

  // jdo holds the last popped data; take_* pulse for exactly one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        jdo <= head_sr;
        if (head_sr[ACTION_BIT]) begin
          take_action <= head_onehot;
        end else begin
          take_no_action <= head_onehot;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sticky overflow
  // --------------------------------------------------------------------------
  // A drop takes priority over a coincident clear so no loss goes unreported
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios2_debug_slave_sysclk_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nios2_debug_slave_sysclk_fifo
// Brief    : Self-checking bench; a queue of expected commands is compared
//            against every take_* pulse observed on the DUT.
// Revision : 1.0
// ============================================================================
module tb_nios2_debug_slave_sysclk_fifo;

  localparam int SRW   = 38;
  localparam int IRW   = 2;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int ABIT  = 35;
  localparam int NCH   = 4;
  localparam int LW    = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [IRW-1:0]   ir_in;
  logic [SRW-1:0]   sr;
  logic             vs_uir;
  logic             vs_udr;
  logic             cmd_ready;
  logic             overflow_clr;
  logic             cmd_valid;
  logic [SRW-1:0]   jdo;
  logic [NCH-1:0]   take_action;
  logic [NCH-1:0]   take_no_action;
  logic             overflow;
  logic [LW-1:0]    fifo_level;

  logic             ready_main;
  logic             ready_rnd;
  logic             rnd_en;
  assign cmd_ready = rnd_en ? ready_rnd : ready_main;

  nios2_debug_slave_sysclk_fifo #(
    .SR_WIDTH   (SRW),
    .IR_WIDTH   (IRW),
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(SYNC),
    .ACTION_BIT (ABIT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ir_in         (ir_in),
    .sr            (sr),
    .vs_uir        (vs_uir),
    .vs_udr        (vs_udr),
    .cmd_ready     (cmd_ready),
    .overflow_clr  (overflow_clr),
    .cmd_valid     (cmd_valid),
    .jdo           (jdo),
    .take_action   (take_action),
    .take_no_action(take_no_action),
    .overflow      (overflow),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model: commands not yet consumed, current IR, expected overflow
  typedef struct packed {
    logic [IRW-1:0] ir;
    logic [SRW-1:0] data;
  } cmd_t;

  cmd_t           exp_q[$];
  logic [IRW-1:0] model_ir;
  logic           model_ovf;
  int             pulse_count;
  int             checks;
  int             failures;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // A command is accepted unless the buffer is full with no pop alongside
  function automatic void model_push(input logic [SRW-1:0] v, input logic pop_same);
    cmd_t c;
    c.ir   = model_ir;
    c.data = v;
    if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(c);
    else model_ovf = 1'b1;
  endfunction

  // Every take pulse must match the oldest outstanding command
  cmd_t           mon_e;
  logic [NCH-1:0] mon_oh;
  always @(negedge clk) begin
    if (reset_n && (take_action != '0 || take_no_action != '0)) begin
      pulse_count++;
      if (exp_q.size() == 0) begin
        check("take_unexpected", {56'd0, take_action, take_no_action}, 64'd0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_oh = 4'b0001 << mon_e.ir;
        check("take_action", take_action, mon_e.data[ABIT] ? mon_oh : 4'b0000);
        check("take_no_action", take_no_action, mon_e.data[ABIT] ? 4'b0000 : mon_oh);
        check("jdo_at_pulse", jdo, mon_e.data);
      end
    end
  end

  // Random consumer back-pressure
  initial begin
    ready_rnd = 1'b0;
    forever begin
      @(negedge clk);
      ready_rnd = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_uir(input logic [IRW-1:0] v);
    @(negedge clk);
    ir_in  = v;
    vs_uir = 1'b1;
    repeat (5) @(negedge clk);
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
    model_ir = v;
  endtask

  task automatic do_udr(input logic [SRW-1:0] v);
    model_push(v, 1'b0);
    @(negedge clk);
    sr     = v;
    vs_udr = 1'b1;
    repeat (5) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Simultaneous IR and DR update: push uses the IR from before this update
  task automatic do_both(input logic [IRW-1:0] iv, input logic [SRW-1:0] v);
    model_push(v, 1'b0);
    model_ir = iv;
    @(negedge clk);
    ir_in  = iv;
    sr     = v;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    repeat (5) @(negedge clk);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Raise vs_udr and drive ready/clr exactly in the edge-detect cycle;
  // returns at the negedge following the push with vs_udr still high
  task automatic udr_rise_edge(input logic [SRW-1:0] v, input logic rdy, input logic clr);
    model_push(v, rdy);
    @(negedge clk);
    sr     = v;
    vs_udr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ready_main   = rdy;
    overflow_clr = clr;
    @(negedge clk);
    ready_main   = 1'b0;
    overflow_clr = 1'b0;
  endtask

  task automatic udr_release();
    repeat (3) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_main = 1'b1;
    while ((exp_q.size() != 0 || cmd_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_outstanding", exp_q.size(), 0);
    check("drain_cmd_valid", cmd_valid, 1'b0);
    ready_main = 1'b0;
  endtask

  function automatic logic [SRW-1:0] rnd_sr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[SRW-1:0];
  endfunction

  initial begin
    int p0;
    int n;
    logic [SRW-1:0] v;
    checks = 0; failures = 0; pulse_count = 0;
    model_ir = '0; model_ovf = 1'b0;
    reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
    ready_main = 1'b0; rnd_en = 1'b0; overflow_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_jdo", jdo, 0);
    check("rst_take_action", take_action, 0);
    check("rst_take_no_action", take_no_action, 0);
    check("rst_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single action command on channel 2
    do_uir(2'd2);
    ready_main = 1'b1;
    p0 = pulse_count;
    do_udr(38'h08_0000_1234);
    repeat (4) @(negedge clk);
    check("single_pulses", pulse_count - p0, 1);
    check("single_jdo_held", jdo, 38'h08_0000_1234);
    check("single_take_idle", {take_action, take_no_action}, 0);

    // No-action command on channel 3
    do_uir(2'd3);
    p0 = pulse_count;
    do_udr(38'h00_dead_beef);
    repeat (4) @(negedge clk);
    check("noact_pulses", pulse_count - p0, 1);
    check("noact_jdo", jdo, 38'h00_dead_beef);

    // Fill to capacity and overflow
    ready_main = 1'b0;
    for (int i = 1; i <= 5; i++) do_udr(SRW'(i));
    check("fill_level", fifo_level, DEPTH);
    check("fill_overflow", overflow, model_ovf);
    check("fill_cmd_valid", cmd_valid, 1'b1);
    drain();
    check("fill_last_jdo", jdo, 38'd4);
    check("fill_level_empty", fifo_level, 0);
    @(negedge clk); overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0; model_ovf = 1'b0;
    check("ovf_cleared", overflow, model_ovf);

    // Push and pop in the same cycle while full
    for (int i = 0; i < DEPTH; i++) do_udr(rnd_sr());
    check("full_level", fifo_level, DEPTH);
    udr_rise_edge(38'h3f_0000_0055, 1'b1, 1'b0);
    check("full_pushpop_level", fifo_level, DEPTH);
    check("full_pushpop_ovf", overflow, 1'b0);
    udr_release();
    drain();

    // Drop coinciding with overflow_clr: set wins
    for (int i = 0; i < DEPTH; i++) do_udr(rnd_sr());
    udr_rise_edge(rnd_sr(), 1'b0, 1'b1);
    check("drop_clr_ovf", overflow, model_ovf);
    udr_release();
    @(negedge clk); overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0; model_ovf = 1'b0;
    check("clr_alone_ovf", overflow, model_ovf);
    drain();

    // Reset with buffered commands and vs_udr held high through release
    do_uir(2'd1);
    do_udr(rnd_sr());
    do_udr(rnd_sr());
    @(negedge clk);
    vs_udr = 1'b1;
    reset_n = 1'b0;
    exp_q.delete();
    model_ir = '0;
    model_ovf = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_held_cmd_valid", cmd_valid, 1'b0);
    check("rst_held_level", fifo_level, 0);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    v = rnd_sr();
    p0 = pulse_count;
    do_udr(v);
    check("rearm_level", fifo_level, 1);
    drain();
    check("rearm_pulses", pulse_count - p0, 1);
    check("rearm_jdo", jdo, v);

    // Randomised traffic with random back-pressure
    rnd_en = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 1) begin
        do_uir(IRW'($urandom_range(0, NCH - 1)));
      end else begin
        n = 0;
        while (fifo_level >= LW'(DEPTH) && n < 500) begin
          @(negedge clk);
          n++;
        end
        if (n >= 500) check("room_timeout", fifo_level < LW'(DEPTH), 1'b1);
        if (kind == 3) do_both(IRW'($urandom_range(0, NCH - 1)), rnd_sr());
        else do_udr(rnd_sr());
      end
    end
    rnd_en = 1'b0;
    drain();
    check("rand_overflow", overflow, model_ovf);
    check("rand_level", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
